matrix_result_serializer: RTL and testbench

- Downstream consumer of the matrix compute stages (scalar multiply, add, transpose), which present results as a 5x5 row-major bank with r_out/c_out.
- On a start pulse it snapshots the bank and dimensions, then streams the valid r x c elements one at a time, row-major, over a valid/ready handshake.
- Feeds the UART/display formatter.

---
 rtl/matrix_result_serializer.sv | 155 +++++++++++++++
 tb/tb_matrix_result_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
// rtl/matrix_result_serializer.sv - snapshots a 5x5 result bank and streams its r x c elements row-major
// Optional MATRIX_SER_ROW_GAP_EN: flags row ends and inserts one idle cycle between rows.
module matrix_result_serializer #(
    parameter int DATA_WIDTH = 9,
    parameter int MAX_DIM    = 5
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [2:0]                             r,
    input  logic [2:0]                             c,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]                  elem_data,
    output logic [2:0]                             elem_row,
    output logic [2:0]                             elem_col,
    output logic                                   elem_valid,
    input  logic                                   elem_ready,
    output logic                                   elem_last,
    output logic                                   row_end,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int         N       = MAX_DIM * MAX_DIM;
    localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
`ifdef MATRIX_SER_ROW_GAP_EN
        S_GAP    = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            col_q, col_d;
    logic [2:0]            r_q, r_d;
    logic [2:0]            c_q, c_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] snap_q [N];
    logic [DATA_WIDTH-1:0] snap_d [N];

    logic       dims_bad;
    logic       col_last;
    logic       row_last;
    logic [4:0] idx;

    assign dims_bad = (r == 3'd0) || (r > DIM_MAX) || (c == 3'd0) || (c > DIM_MAX);
    assign col_last = (col_q == c_q - 3'd1);
    assign row_last = (row_q == r_q - 3'd1);
    // Bank stride is always MAX_DIM regardless of the active column count.
    assign idx      = 5'(row_q) * 5'(MAX_DIM) + 5'(col_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            r_q     <= r_d;
            c_q     <= c_d;
            err_q   <= err_d;
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        r_d     = r_q;
        c_d     = c_q;
        err_d   = err_q;
        for (int k = 0; k < N; k++) begin
            snap_d[k] = snap_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d   = r;
                    c_d   = c;
                    row_d = '0;
                    col_d = '0;
                    for (int k = 0; k < N; k++) begin
                        snap_d[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (dims_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (elem_ready) begin
                    if (!col_last) begin
                        col_d = col_q + 3'd1;
                    end else if (!row_last) begin
                        col_d = '0;
                        row_d = row_q + 3'd1;
`ifdef MATRIX_SER_ROW_GAP_EN
                        state_d = S_GAP;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef MATRIX_SER_ROW_GAP_EN
            S_GAP: begin
                state_d = S_STREAM;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Element outputs are zero outside STREAM so the consumer never sees stale indices.
    assign elem_valid = (state_q == S_STREAM);
    assign elem_data  = elem_valid ? snap_q[idx] : '0;
    assign elem_row   = elem_valid ? row_q : '0;
    assign elem_col   = elem_valid ? col_q : '0;
    assign elem_last  = elem_valid && row_last && col_last;
`ifdef MATRIX_SER_ROW_GAP_EN
    assign row_end    = elem_valid && col_last;
`else
    assign row_end    = 1'b0;
`endif
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// tb/tb_matrix_result_serializer.sv - scoreboard bench for matrix_result_serializer
module tb_matrix_result_serializer;

    localparam int DW = 9;
`ifdef MATRIX_SER_ROW_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        r = '0;
    logic [2:0]        c = '0;
    logic [25*DW-1:0]  data_in = '0;
    logic [DW-1:0]     elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              elem_valid;
    logic              elem_ready = 1'b0;
    logic              elem_last;
    logic              row_end;
    logic              busy;
    logic              done;
    logic              err;

    matrix_result_serializer #(.DATA_WIDTH(DW), .MAX_DIM(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .r(r), .c(c), .data_in(data_in),
        .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last),
        .row_end(row_end), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    row;
        logic [2:0]    col;
        logic          last;
        logic          rend;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_matrix(input int rr, input int cc, input logic [25*DW-1:0] bank);
        exp_t e;
        for (int i = 0; i < rr; i++) begin
            for (int j = 0; j < cc; j++) begin
                e.d    = bank[(i*5+j)*DW +: DW];
                e.row  = 3'(i);
                e.col  = 3'(j);
                e.last = (i == rr-1) && (j == cc-1);
                e.rend = (GAP_EN != 0) && (j == cc-1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_start(input logic [2:0] rr, input logic [2:0] cc, input logic [25*DW-1:0] bank);
        @(negedge clk);
        r       = rr;
        c       = cc;
        data_in = bank;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: ready high; mode 1: ready toggles 1/0. stop_after 0 runs until done.
    task automatic drain(input int mode, input int stop_after, output int n_elem, output int n_busy,
                         output int first_v, output int last_hs, output int done_at, output logic done_err);
        logic          pv_stall;
        logic [17:0]   prev;
        exp_t          e;
        pv_stall = 1'b0;
        prev     = '0;
        n_elem   = 0;
        n_busy   = 0;
        first_v  = -1;
        last_hs  = -1;
        done_at  = -1;
        done_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            elem_ready = (mode == 0) ? 1'b1 : ((i % 2) == 0);
            if (busy) n_busy++;
            if (pv_stall)
                chk("stall_stable", 32'({elem_valid, elem_data, elem_row, elem_col, elem_last, row_end}), 32'(prev));
            if (elem_valid && first_v < 0) first_v = i;
            if (done) begin
                done_at  = i;
                done_err = err;
                break;
            end
            if (elem_valid && elem_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_elem", 32'(elem_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("elem_data", 32'(elem_data), 32'(e.d));
                    chk("elem_row", 32'(elem_row), 32'(e.row));
                    chk("elem_col", 32'(elem_col), 32'(e.col));
                    chk("elem_last", 32'(elem_last), 32'(e.last));
                    chk("row_end", 32'(row_end), 32'(e.rend));
                end
                n_elem++;
                last_hs = i;
                if (n_elem == stop_after) break;
            end
            pv_stall = elem_valid && !elem_ready;
            prev     = {elem_valid, elem_data, elem_row, elem_col, elem_last, row_end};
        end
        if (stop_after == 0 && done_at < 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    logic [25*DW-1:0] bank;
    logic [25*DW-1:0] bank2;
    int               n_elem, n_busy, first_v, last_hs, done_at;
    logic             done_err;

    initial begin
        for (int k = 0; k < 25; k++) bank[k*DW +: DW] = DW'(k);

        // Reset state
        @(negedge clk);
        chk("reset_outputs", 32'({elem_data, elem_row, elem_col, elem_valid, elem_last, row_end, busy, done, err}), 32'd0);
        reset_n = 1'b1;

        // 2x3, ready high, bank k = k
        do_start(3'd2, 3'd3, bank);
        push_matrix(2, 3, bank);
        drain(0, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("m2x3_count", 32'(n_elem), 32'd6);
        chk("m2x3_first_valid", 32'(first_v), 32'd0);
        chk("m2x3_done_latency", 32'(done_at), 32'(last_hs + 1));
        chk("m2x3_busy_cycles", 32'(n_busy), 32'(6 + 1 + GAP_EN));
        chk("m2x3_err", 32'(done_err), 32'd0);
        chk("m2x3_sb_empty", 32'(sb.size()), 32'd0);

        // 5x5, random data, ready toggling
        for (int k = 0; k < 25; k++) bank2[k*DW +: DW] = DW'($urandom);
        do_start(3'd5, 3'd5, bank2);
        push_matrix(5, 5, bank2);
        drain(1, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("m5x5_count", 32'(n_elem), 32'd25);
        chk("m5x5_done_latency", 32'(done_at), 32'(last_hs + 1));
        chk("m5x5_sb_empty", 32'(sb.size()), 32'd0);

        // Illegal dimensions
        do_start(3'd0, 3'd3, bank);
        drain(0, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("ill0_no_valid", 32'(first_v), 32'hFFFF_FFFF);
        chk("ill0_done_at", 32'(done_at), 32'd0);
        chk("ill0_busy_cycles", 32'(n_busy), 32'd1);
        chk("ill0_err", 32'(done_err), 32'd1);
        do_start(3'd6, 3'd2, bank);
        drain(0, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("ill6_no_valid", 32'(n_elem), 32'd0);
        chk("ill6_done_at", 32'(done_at), 32'd0);
        chk("ill6_err", 32'(done_err), 32'd1);
        @(negedge clk);
        chk("err_held", 32'({err, done, busy}), 32'b100);

        // 1x4 with re-pulsed start and changed inputs mid-stream
        for (int k = 0; k < 25; k++) bank2[k*DW +: DW] = DW'(k + 100);
        do_start(3'd1, 3'd4, bank2);
        push_matrix(1, 4, bank2);
        @(negedge clk);
        elem_ready = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        start   = 1'b1;
        r       = 3'd5;
        c       = 3'd5;
        data_in = ~bank2;
        @(negedge clk);
        start = 1'b0;
        drain(1, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("m1x4_count", 32'(n_elem), 32'd4);
        chk("m1x4_sb_empty", 32'(sb.size()), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 32'({busy, elem_valid}), 32'd0);

        // 1x1
        bank2[0 +: DW] = 9'h1A5;
        do_start(3'd1, 3'd1, bank2);
        push_matrix(1, 1, bank2);
        drain(0, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("m1x1_count", 32'(n_elem), 32'd1);
        chk("m1x1_done_latency", 32'(done_at), 32'd1);

        // Reset mid-stream after 4th handshake of a 3x3
        do_start(3'd3, 3'd3, bank);
        push_matrix(3, 3, bank);
        drain(0, 4, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("rst_partial_count", 32'(n_elem), 32'd4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_outputs", 32'({elem_data, elem_row, elem_col, elem_valid, elem_last, row_end, busy, done, err}), 32'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        do_start(3'd3, 3'd3, bank);
        push_matrix(3, 3, bank);
        drain(0, 0, n_elem, n_busy, first_v, last_hs, done_at, done_err);
        chk("rst_restream_count", 32'(n_elem), 32'd9);
        chk("rst_restream_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
